// File: rtl/mouse_packet_tracker_pkg.sv
// Shared types and status-byte layout for the PS/2 mouse packet tracker.
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_STATUS,
    WAIT_DX,
    WAIT_DY,
    WAIT_DZ
  } state_t;

  localparam int unsigned STAT_L    = 0;
  localparam int unsigned STAT_R    = 1;
  localparam int unsigned STAT_M    = 2;
  localparam int unsigned STAT_SYNC = 3;
  localparam int unsigned STAT_XS   = 4;
  localparam int unsigned STAT_YS   = 5;
  localparam int unsigned STAT_XO   = 6;
  localparam int unsigned STAT_YO   = 7;

  // Status byte fields retained until commit; the sync bit is not needed after capture.
  typedef struct packed {
    logic yo;
    logic xo;
    logic ys;
    logic xs;
    logic m;
    logic r;
    logic l;
  } status_t;

  function automatic logic signed [8:0] axis_delta(input logic sign, input logic ovf,
                                                   input logic [7:0] mag);
    return ovf ? 9'sd0 : $signed({sign, mag});
  endfunction

endpackage

// File: rtl/mouse_packet_tracker_axis_accum.sv
// One screen axis: apply a signed 9-bit mouse delta to a position and clamp to 0..LIMIT-1.
module mouse_axis_accum #(
  parameter int unsigned W      = 8,
  parameter int unsigned LIMIT  = 160,
  parameter bit          INVERT = 1'b0
) (
  input  logic [W-1:0]      pos,
  input  logic signed [8:0] delta,
  output logic [W-1:0]      pos_next
);

  // Two guard bits above W cover any 9-bit delta in either direction.
  localparam int unsigned SW = (W + 2 > 10) ? W + 2 : 10;
  localparam logic signed [SW-1:0] MAX_POS = SW'(LIMIT - 1);

  logic signed [SW-1:0] cur;
  logic signed [SW-1:0] step;
  logic signed [SW-1:0] sum;

  always_comb begin
    cur  = $signed({{(SW - W){1'b0}}, pos});
    step = {{(SW - 9){delta[8]}}, delta};
    sum  = INVERT ? (cur - step) : (cur + step);
    if (sum < 0) begin
      pos_next = '0;
    end else if (sum > MAX_POS) begin
      pos_next = MAX_POS[W-1:0];
    end else begin
      pos_next = sum[W-1:0];
    end
  end

endmodule

// File: rtl/mouse_packet_tracker.sv
// Assembles mouse byte-stream packets and tracks clamped X/Y, wrapping wheel Z and buttons.
module mouse_packet_tracker
  import mouse_pkg::*;
#(
  parameter int unsigned PACKET_BYTES   = 3,
  parameter int unsigned COORD_W        = 8,
  parameter int unsigned LIMIT_X        = 160,
  parameter int unsigned LIMIT_Y        = 120,
  parameter int unsigned WHEEL_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned INVERT_Y       = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BYTE_READY,
  input  logic [7:0]         BYTE_READ,
  input  logic [1:0]         BYTE_ERROR_CODE,
  input  logic               CENTRE,
  output logic [COORD_W-1:0] MOUSE_X,
  output logic [COORD_W-1:0] MOUSE_Y,
  output logic [WHEEL_W-1:0] MOUSE_Z,
  output logic [2:0]         MOUSE_BUTTONS,
  output logic               PACKET_VALID,
  output logic               SYNC_ERROR
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
  localparam state_t LAST_STATE = (PACKET_BYTES == 4) ? WAIT_DZ : WAIT_DY;
  localparam logic [COORD_W-1:0] CENTRE_X = COORD_W'(LIMIT_X / 2);
  localparam logic [COORD_W-1:0] CENTRE_Y = COORD_W'(LIMIT_Y / 2);

  state_t        state_q, state_d;
  logic [CW-1:0] to_cnt;
  status_t       status_q;
  logic [7:0]    dx_q, dy_q;

  logic commit, sync_err, cap_status, cap_dx, cap_dy, timeout;
  logic [7:0] dy_byte;
  logic [3:0] dz_nib;
  logic signed [8:0] dx, dy;
  logic [WHEEL_W-1:0] dz;
  logic [COORD_W-1:0] x_next, y_next;

  assign timeout = (state_q != WAIT_STATUS) && !BYTE_READY && (to_cnt == TO_MAX);

  always_comb begin
    state_d    = state_q;
    commit     = 1'b0;
    sync_err   = 1'b0;
    cap_status = 1'b0;
    cap_dx     = 1'b0;
    cap_dy     = 1'b0;
    if (BYTE_READY) begin
      if (BYTE_ERROR_CODE != '0) begin
        sync_err = 1'b1;
        state_d  = WAIT_STATUS;
      end else begin
        case (state_q)
          WAIT_STATUS: begin
            if (BYTE_READ[STAT_SYNC]) begin
              cap_status = 1'b1;
              state_d    = WAIT_DX;
            end else begin
              sync_err = 1'b1;
            end
          end
          WAIT_DX: begin
            cap_dx  = 1'b1;
            state_d = WAIT_DY;
          end
          WAIT_DY: begin
            if (LAST_STATE == WAIT_DY) begin
              commit  = 1'b1;
              state_d = WAIT_STATUS;
            end else begin
              cap_dy  = 1'b1;
              state_d = WAIT_DZ;
            end
          end
          WAIT_DZ: begin
            commit  = 1'b1;
            state_d = WAIT_STATUS;
          end
          default: state_d = WAIT_STATUS;
        endcase
      end
    end else if (timeout) begin
      sync_err = 1'b1;
      state_d  = WAIT_STATUS;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= WAIT_STATUS;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      to_cnt  <= (BYTE_READY || state_q == WAIT_STATUS) ? '0 : to_cnt + CW'(1);
    end
  end

  // The final byte is consumed straight from the input, so the commit needs no extra cycle.
  always_comb begin
    dy_byte = (PACKET_BYTES == 4) ? dy_q : BYTE_READ;
    dz_nib  = (PACKET_BYTES == 4) ? BYTE_READ[3:0] : 4'h0;
    dx      = axis_delta(status_q.xs, status_q.xo, dx_q);
    dy      = axis_delta(status_q.ys, status_q.yo, dy_byte);
    dz      = {{(WHEEL_W - 4){dz_nib[3]}}, dz_nib};
  end

  mouse_axis_accum #(.W(COORD_W), .LIMIT(LIMIT_X), .INVERT(1'b0)) u_axis_x (
    .pos      (MOUSE_X),
    .delta    (dx),
    .pos_next (x_next)
  );

  mouse_axis_accum #(.W(COORD_W), .LIMIT(LIMIT_Y), .INVERT(INVERT_Y != 0)) u_axis_y (
    .pos      (MOUSE_Y),
    .delta    (dy),
    .pos_next (y_next)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      status_q      <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      MOUSE_X       <= CENTRE_X;
      MOUSE_Y       <= CENTRE_Y;
      MOUSE_Z       <= '0;
      MOUSE_BUTTONS <= '0;
      PACKET_VALID  <= 1'b0;
      SYNC_ERROR    <= 1'b0;
    end else begin
      PACKET_VALID <= commit;
      SYNC_ERROR   <= sync_err;
      if (cap_status) begin
        status_q <= '{yo: BYTE_READ[STAT_YO], xo: BYTE_READ[STAT_XO],
                      ys: BYTE_READ[STAT_YS], xs: BYTE_READ[STAT_XS],
                      m:  BYTE_READ[STAT_M],  r:  BYTE_READ[STAT_R],
                      l:  BYTE_READ[STAT_L]};
      end
      if (cap_dx) dx_q <= BYTE_READ;
      if (cap_dy) dy_q <= BYTE_READ;
      if (commit) MOUSE_BUTTONS <= {status_q.m, status_q.r, status_q.l};
      if (CENTRE) begin
        MOUSE_X <= CENTRE_X;
        MOUSE_Y <= CENTRE_Y;
        MOUSE_Z <= '0;
      end else if (commit) begin
        MOUSE_X <= x_next;
        MOUSE_Y <= y_next;
        MOUSE_Z <= MOUSE_Z + dz;
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Bench for mouse_packet_tracker: vector table, corner-case sequences and a randomized model check.
module tb_mouse_packet_tracker;

  localparam int T  = 40;
  localparam int LX = 160;
  localparam int LY = 120;

  logic       clk;
  logic       rst_n;
  logic       rdy3, rdy4, cen3, cen4;
  logic [7:0] byte_in;
  logic [1:0] err_in;
  logic [7:0] x3, y3, z3, x4, y4, z4;
  logic [2:0] btn3, btn4;
  logic       v3, s3, v4, s4;

  int checks = 0;
  int errors = 0;

  mouse_packet_tracker #(.PACKET_BYTES(3), .TIMEOUT_CYCLES(T)) dut3 (
    .CLK(clk), .RESET(rst_n), .BYTE_READY(rdy3), .BYTE_READ(byte_in),
    .BYTE_ERROR_CODE(err_in), .CENTRE(cen3), .MOUSE_X(x3), .MOUSE_Y(y3),
    .MOUSE_Z(z3), .MOUSE_BUTTONS(btn3), .PACKET_VALID(v3), .SYNC_ERROR(s3)
  );

  mouse_packet_tracker #(.PACKET_BYTES(4), .TIMEOUT_CYCLES(T)) dut4 (
    .CLK(clk), .RESET(rst_n), .BYTE_READY(rdy4), .BYTE_READ(byte_in),
    .BYTE_ERROR_CODE(err_in), .CENTRE(cen4), .MOUSE_X(x4), .MOUSE_Y(y4),
    .MOUSE_Z(z4), .MOUSE_BUTTONS(btn4), .PACKET_VALID(v4), .SYNC_ERROR(s4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       rdy;
    logic [7:0] b;
    logic [1:0] err;
    logic       centre;
    int         v, s, x, y, btn;
  } vec_t;
  vec_t tbl[$];

  // Reference model: bytes of the packet in progress plus absolute position state.
  logic [7:0] pkt[$];
  int mx, my, mz, mbtn;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic void model_reset();
    pkt.delete();
    mx = LX / 2; my = LY / 2; mz = 0; mbtn = 0;
  endfunction

  task automatic model_step(input int n, input logic r, input logic [7:0] b,
                            input logic [1:0] e, input logic c, output int ev, output int es);
    logic [7:0] s, b1, b2, b3;
    int dx, dy, dz;
    ev = 0; es = 0;
    if (r) begin
      if (e != 0) begin
        es = 1;
        pkt.delete();
      end else if (pkt.size() == 0 && b[3] == 1'b0) begin
        es = 1;
      end else begin
        pkt.push_back(b);
        if (pkt.size() == n) begin
          s  = pkt[0];
          b1 = pkt[1];
          b2 = pkt[2];
          b3 = (n == 4) ? pkt[3] : 8'h00;
          dx = s[6] ? 0 : int'(b1) - (s[4] ? 256 : 0);
          dy = s[7] ? 0 : int'(b2) - (s[5] ? 256 : 0);
          dz = (n == 4) ? int'(b3[3:0]) - (b3[3] ? 16 : 0) : 0;
          mx = clampi(mx + dx, 0, LX - 1);
          my = clampi(my - dy, 0, LY - 1);
          mz = (mz + dz + 256) % 256;
          mbtn = int'(s[2]) * 4 + int'(s[1]) * 2 + int'(s[0]);
          ev = 1;
          pkt.delete();
        end
      end
    end
    if (c) begin
      mx = LX / 2; my = LY / 2; mz = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input int sel, input string tag, input int ev, input int es,
                         input int ex, input int ey, input int ez, input int eb);
    chk({tag, "_valid"}, (sel == 3) ? int'(v3) : int'(v4), ev);
    chk({tag, "_sync"},  (sel == 3) ? int'(s3) : int'(s4), es);
    chk({tag, "_x"},     (sel == 3) ? int'(x3) : int'(x4), ex);
    chk({tag, "_y"},     (sel == 3) ? int'(y3) : int'(y4), ey);
    chk({tag, "_z"},     (sel == 3) ? int'(z3) : int'(z4), ez);
    chk({tag, "_btn"},   (sel == 3) ? int'(btn3) : int'(btn4), eb);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic drive(input int sel, input logic r, input logic [7:0] b,
                       input logic [1:0] e, input logic c);
    byte_in = b; err_in = e;
    if (sel == 3) begin rdy3 = r; cen3 = c; end
    else begin rdy4 = r; cen4 = c; end
    @(posedge clk); #1;
    rdy3 = 1'b0; rdy4 = 1'b0; cen3 = 1'b0; cen4 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic add(input logic r, input logic [7:0] b, input logic [1:0] e, input logic c,
                     input int v, input int s, input int x, input int y, input int btn);
    vec_t t;
    t.rdy = r; t.b = b; t.err = e; t.centre = c;
    t.v = v; t.s = s; t.x = x; t.y = y; t.btn = btn;
    tbl.push_back(t);
  endtask

  int k, ev, es, streak;
  logic       r_r, c_r;
  logic [7:0] b_r;
  logic [1:0] e_r;

  initial begin
    rst_n = 1'b0; rdy3 = 1'b0; rdy4 = 1'b0; cen3 = 1'b0; cen4 = 1'b0;
    byte_in = '0; err_in = '0;
    model_reset();

    // Vector table for the 3-byte instance, starting from reset.
    add(1, 8'h08, 0, 0, 0, 0, 80, 60, 0);
    add(1, 8'h05, 0, 0, 0, 0, 80, 60, 0);
    add(1, 8'h03, 0, 0, 1, 0, 85, 57, 0);
    add(0, 8'h00, 0, 0, 0, 0, 85, 57, 0);
    add(1, 8'h00, 0, 0, 0, 1, 85, 57, 0);
    add(0, 8'h00, 0, 0, 0, 0, 85, 57, 0);
    add(1, 8'h09, 0, 0, 0, 0, 85, 57, 0);
    add(1, 8'h01, 0, 0, 0, 0, 85, 57, 0);
    add(1, 8'hFF, 0, 0, 1, 0, 86, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 80, 60, 1);
    for (int p = 0; p < 9; p++) begin
      k = (p == 0) ? 80 : clampi(70 - 10 * (p - 1), 0, 255);
      add(1, 8'h18, 0, 0, 0, 0, k, 60, (p == 0) ? 1 : 0);
      add(1, 8'hF6, 0, 0, 0, 0, k, 60, (p == 0) ? 1 : 0);
      add(1, 8'h00, 0, 0, 1, 0, clampi(70 - 10 * p, 0, 255), 60, 0);
    end
    add(0, 8'h00, 0, 1, 0, 0, 80, 60, 0);
    for (int p = 0; p < 2; p++) begin
      add(1, 8'h08, 0, 0, 0, 0, (p == 0) ? 80 : 159, 60, 0);
      add(1, 8'hC8, 0, 0, 0, 0, (p == 0) ? 80 : 159, 60, 0);
      add(1, 8'h00, 0, 0, 1, 0, 159, 60, 0);
    end
    add(1, 8'h28, 0, 0, 0, 0, 159, 60, 0);
    add(1, 8'h00, 0, 0, 0, 0, 159, 60, 0);
    add(1, 8'h00, 0, 0, 1, 0, 159, 119, 0);
    add(1, 8'h08, 1, 0, 0, 1, 159, 119, 0);
    add(1, 8'h08, 0, 0, 0, 0, 159, 119, 0);
    add(1, 8'h11, 2, 0, 0, 1, 159, 119, 0);
    add(1, 8'h18, 0, 0, 0, 0, 159, 119, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 159, 119, 0);
    add(1, 8'h01, 0, 0, 1, 0, 158, 118, 0);
    add(1, 8'h8F, 0, 0, 0, 0, 158, 118, 0);
    add(1, 8'h02, 0, 0, 0, 0, 158, 118, 0);
    add(1, 8'h05, 0, 0, 1, 0, 159, 118, 7);
    add(0, 8'h00, 0, 0, 0, 0, 159, 118, 7);

    repeat (2) @(posedge clk);
    #1;
    chk_all(3, "reset3", 0, 0, 80, 60, 0, 0);
    chk_all(4, "reset4", 0, 0, 80, 60, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(3, tbl[i].rdy, tbl[i].b, tbl[i].err, tbl[i].centre);
      chk_all(3, $sformatf("row%0d", i), tbl[i].v, tbl[i].s, tbl[i].x, tbl[i].y, 0, tbl[i].btn);
    end

    // Timeout: SYNC_ERROR lands T+1 edges after the lone status byte.
    do_reset();
    drive(3, 1, 8'h08, 0, 0);
    k = 0;
    for (int i = 1; i <= T + 10; i++) begin
      drive(3, 0, 8'h00, 0, 0);
      if (s3 && k == 0) k = i;
    end
    chk("timeout_latency", k, T + 1);
    drive(3, 1, 8'h08, 0, 0);
    drive(3, 1, 8'h05, 0, 0);
    drive(3, 1, 8'h03, 0, 0);
    chk_all(3, "after_timeout", 1, 0, 85, 57, 0, 0);

    // Byte arriving in the same cycle the timeout would expire is still accepted.
    do_reset();
    drive(3, 1, 8'h08, 0, 0);
    repeat (T) drive(3, 0, 8'h00, 0, 0);
    drive(3, 1, 8'h01, 0, 0);
    chk("tie_sync", int'(s3), 0);
    drive(3, 1, 8'h00, 0, 0);
    chk_all(3, "tie_commit", 1, 0, 81, 60, 0, 0);

    // Reset mid-packet drops the partial packet silently.
    do_reset();
    drive(3, 1, 8'h08, 0, 0);
    drive(3, 1, 8'h05, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midreset_sync", int'(s3), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(3, 1, 8'h08, 0, 0);
    chk("midreset_first_valid", int'(v3), 0);
    drive(3, 1, 8'h05, 0, 0);
    drive(3, 1, 8'h03, 0, 0);
    chk_all(3, "midreset_commit", 1, 0, 85, 57, 0, 0);

    // CENTRE coinciding with the final byte.
    do_reset();
    drive(3, 1, 8'h0C, 0, 0);
    drive(3, 1, 8'h05, 0, 0);
    drive(3, 1, 8'h00, 0, 1);
    chk_all(3, "centre_commit", 1, 0, 80, 60, 0, 4);

    // Wheel mode.
    do_reset();
    drive(4, 1, 8'h08, 0, 0);
    drive(4, 1, 8'h00, 0, 0);
    drive(4, 1, 8'h00, 0, 0);
    chk("wheel_third_valid", int'(v4), 0);
    drive(4, 1, 8'h0F, 0, 0);
    chk_all(4, "wheel_neg", 1, 0, 80, 60, 255, 0);
    drive(4, 1, 8'h4A, 0, 0);
    drive(4, 1, 8'h7F, 0, 0);
    drive(4, 1, 8'h01, 0, 0);
    drive(4, 1, 8'h00, 0, 0);
    chk_all(4, "wheel_xovf", 1, 0, 80, 59, 255, 2);
    drive(4, 1, 8'h08, 0, 0);
    drive(4, 1, 8'h00, 0, 0);
    drive(4, 1, 8'h00, 0, 0);
    drive(4, 1, 8'h07, 0, 0);
    chk_all(4, "wheel_wrap_up", 1, 0, 80, 59, 6, 0);

    // Randomized stream against the reference model, both packet sizes.
    for (int sel = 3; sel <= 4; sel++) begin
      do_reset();
      streak = 0;
      for (int i = 0; i < 400; i++) begin
        r_r = ($urandom_range(0, 9) < 7) || (streak >= 10);
        streak = r_r ? 0 : streak + 1;
        b_r = 8'($urandom);
        if (pkt.size() == 0 && $urandom_range(0, 9) < 8) b_r[3] = 1'b1;
        e_r = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        c_r = ($urandom_range(0, 29) == 0);
        model_step(sel, r_r, b_r, e_r, c_r, ev, es);
        drive(sel, r_r, b_r, e_r, c_r);
        chk_all(sel, $sformatf("rnd%0d_%0d", sel, i), ev, es, mx, my, mz, mbtn);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
